rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares a single N:1 bit-select mux among N requesters. It sequences the mux select so that each requester gets exclusive, bounded-length access. It also presents the selected input bit on a single output. It sits in front of the team's N-to-1 mux datapath and is the only block that drives its select.

## Interface
- `N`, default 8: number of requesters / mux inputs (N ≥ 2, need not be a power of two).
- `HOLD`, default 4: maximum consecutive cycles one grant may last (HOLD ≥ 1).
- `M` (localparam) = `$clog2(N)`: select width.
- `C` (localparam) = `$clog2(HOLD+1)`: hold-counter width.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  N  request per requester, level-sensitive.
- `in`  input  N  data bit per requester.
- `sel`  output  M  registered mux select, index of current/last grantee.
- `gnt`  output  N  registered one-hot grant; all-zero when idle.
- `busy`  output  1  registered; 1 while a grant is active.
- `out`  output  1  combinational: `in[sel]` when `busy`, else 0.

## Operation
- States: IDLE (`busy`=0) and GRANT (`busy`=1).
- Internal registers: `ptr` [M-1:0], the highest-priority index for the next arbitration; `cnt` [C-1:0], the cycles the current grant has been active.
- Reset (asynchronous, `rst_n`=0): `sel`=0, `gnt`=0, `busy`=0, `ptr`=0, `cnt`=0, state IDLE; therefore `out`=0.
- At each rising edge, compute `release` = `busy` && (`req[sel]`==0 || `cnt`==HOLD).
- Arbitration happens when `!busy` or `release`:
  - Base index: `sel+1` (mod N) if `release`, else `ptr`.
  - Winner: the first index i with `req[i]`=1, scanning base, base+1, …, N-1, 0, …, base-1.
  - If a winner exists: `busy`<=1, `sel`<=winner, `gnt`<=onehot(winner), `cnt`<=1, `ptr`<=(winner+1) mod N.
  - If no winner exists: `busy`<=0, `gnt`<=0, `cnt`<=0; `sel` and `ptr` hold.
- Otherwise, when `busy` and not `release`: `cnt`<=`cnt`+1; `sel`, `gnt`, and `ptr` hold.
- Wrap-around: every index increment is modulo N, so index N-1 is followed by 0. `sel` never takes values ≥ N.
- Re-grant to the holder: on HOLD expiry, the holder competes at lowest priority. If it is the only requester, it is re-granted with `cnt`=1.
- Back-to-back handoff: release and the new grant occur on the same edge, with no idle bubble.
- `gnt` is always either zero or one-hot, and equals onehot(`sel`) whenever `busy`=1.

## Timing
- Grant latency: a `req` seen at edge k while IDLE gives `gnt`/`busy`/`sel` valid after edge k, i.e. 1 cycle.
- Grant length: at most HOLD cycles. `cnt` reads 1 in the first granted cycle and HOLD in the last.
- Early release: if the grantee drops `req` in the cycle before edge k, the grant ends at edge k. The next grant, if any, is visible in the same cycle.
- `out` follows `in` and `sel` combinationally, with 0 cycles latency.
- Request changes take effect only at edges; `req` is not latched, so a pulse that falls between arbitration edges is lost.
- Reset asserted mid-grant immediately forces all outputs to their reset values. After `rst_n` rises, arbitration restarts from `ptr`=0 at the first edge.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 (N=4, HOLD=4) -> `busy`=0, `gnt`=0, `sel`=0, `out`=0. On release, first edge -> `sel`=0, `gnt`=4'b0001.
- Single requester: `req`=4'b0100 held, `in`=4'b0100 -> `sel`=2 after 1 edge, `out`=1. Grant lasts 4 cycles, then re-grant with no bubble; `busy` stays 1 throughout.
- Round-robin rotation: `req`=4'b1111 held -> grants 0,1,2,3,0, each exactly 4 cycles; `gnt` never zero and never multi-hot.
- Early release and handoff: grantee 1 drops `req` after 2 cycles while `req[3]`=1 -> `sel`=3 on the next edge; requester 2 (`req[2]`=0) is skipped.
- Wrap and idle: grantee 3 releases with `req`=4'b0001 -> `sel`=0. Then all `req`=0 -> `busy`=0, `gnt`=0, `sel` holds 0, `out`=0.
- Reset mid-grant: assert `rst_n`=0 while `sel`=2, `cnt`=2 -> outputs clear asynchronously, without waiting for an edge. Deassert with `req`=4'b0110 -> first grant goes to 1 (`ptr`=0).

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Purpose : round-robin arbiter driving the select of a shared N:1 bit mux, bounded grant length.
// Latency : grant/sel/busy registered, 1 cycle after req is seen; out is combinational (0 cycles).
// Backpr. : none; req is level-sensitive and unlatched, a holder keeps the grant up to HOLD cycles.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   req   - per-requester request level [N]
//   in    - per-requester data bit [N]
//   sel   - registered mux select (index of current/last grantee) [M]
//   gnt   - registered one-hot grant, zero when idle [N]
//   busy  - registered, high while a grant is active
//   out   - in[sel] while busy, else 0
module rr_mux_arbiter #(
    parameter int N    = 8,
    parameter int HOLD = 4,
    localparam int M   = $clog2(N),
    localparam int C   = $clog2(HOLD + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] in,
    output logic [M-1:0] sel,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [M-1:0] sel_q, sel_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [M-1:0] ptr_q, ptr_d;
    logic [C-1:0] cnt_q, cnt_d;

    // Index increment modulo N; N need not be a power of two, so the
    // natural M-bit wrap cannot be relied on.
    function automatic logic [M-1:0] inc_mod(input logic [M-1:0] v);
        if (v == M'(N - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    logic         busy_w;
    logic         release_w;
    logic [M-1:0] base;
    logic         found;
    logic [M-1:0] win;
    int           sum;

    assign busy_w    = (state_q == GRANT);
    // A grant ends when the holder drops its request or has used all HOLD cycles.
    assign release_w = busy_w && (!req[sel_q] || (cnt_q == C'(HOLD)));
    // After a release the holder goes to the back of the line, so the scan
    // starts just past it; from idle it starts at the rotating pointer.
    assign base      = release_w ? inc_mod(sel_q) : ptr_q;

    // Circular priority scan starting at base.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = 0;
        for (int j = 0; j < N; j++) begin
            sum = int'(base) + j;
            if (sum >= N) begin
                sum = sum - N;
            end
            if (!found && req[sum[M-1:0]]) begin
                found = 1'b1;
                win   = sum[M-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    sel_d      = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    cnt_d      = C'(1);
                    ptr_d      = inc_mod(win);
                end
            end
            GRANT: begin
                if (release_w) begin
                    // Handoff happens on the same edge as the release: no idle bubble.
                    if (found) begin
                        state_d    = GRANT;
                        sel_d      = win;
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        cnt_d      = C'(1);
                        ptr_d      = inc_mod(win);
                    end else begin
                        // sel and ptr keep their values so sel still names the last grantee.
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_w;
    assign out  = busy_w ? in[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter (N=4, HOLD=4): directed scenarios with literal
// expectations, then randomized requests/data/resets, all outputs compared
// every cycle against a behavioural model of the arbitration rules.
module tb_rr_mux_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int M    = $clog2(N);

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] din;
    logic [M-1:0] sel;
    logic [N-1:0] gnt;
    logic         busy;
    logic         dout;

    int n_cmp = 0;
    int n_bad = 0;

    rr_mux_arbiter #(.N(N), .HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .in    (din),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy),
        .out   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    // First requester found walking circularly from base; -1 if nobody asks.
    function automatic int pick(input logic [N-1:0] r, input int base);
        for (int k = 0; k < N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic int rel_now(input logic [N-1:0] r, input int b, input int s, input int c);
        return (b != 0 && (r[s] == 1'b0 || c == HOLD)) ? 1 : 0;
    endfunction

    function automatic int winner_now(input logic [N-1:0] r, input int b, input int s, input int p, input int c);
        if (rel_now(r, b, s, c) != 0) return pick(r, (s + 1) % N);
        return pick(r, p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_sel  <= 0;
            m_ptr  <= 0;
            m_cnt  <= 0;
        end else if (m_busy == 0 || rel_now(req, m_busy, m_sel, m_cnt) != 0) begin
            if (winner_now(req, m_busy, m_sel, m_ptr, m_cnt) >= 0) begin
                m_busy <= 1;
                m_sel  <= winner_now(req, m_busy, m_sel, m_ptr, m_cnt);
                m_ptr  <= (winner_now(req, m_busy, m_sel, m_ptr, m_cnt) + 1) % N;
                m_cnt  <= 1;
            end else begin
                m_busy <= 0;
                m_cnt  <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_sel",  int'(sel),  m_sel);
        chk("m_busy", int'(busy), m_busy);
        chk("m_gnt",  int'(gnt),  (m_busy != 0) ? (1 << m_sel) : 0);
        chk("m_out",  int'(dout), (m_busy != 0) ? int'(din[m_sel]) : 0);
    end

    // ---------------- stimulus ----------------
    // adv: from the drive point, through one rising edge, to 1 time unit after the falling edge.
    task automatic adv();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d);
        #1;
        req = r;
        din = d;
    endtask

    task automatic lit(input string name, input int s, input int g, input int b, input int o);
        chk({name, "_sel"},  int'(sel),  s);
        chk({name, "_gnt"},  int'(gnt),  g);
        chk({name, "_busy"}, int'(busy), b);
        chk({name, "_out"},  int'(dout), o);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        din   = 4'b0000;

        // Reset held with all requesting.
        adv();
        adv();
        lit("reset", 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        // Rotation 0,1,2,3,0 with 4 cycles each.
        for (int k = 1; k <= 20; k++) begin
            adv();
            chk("rot_sel", int'(sel), ((k - 1) / HOLD) % N);
            chk("rot_gnt", int'(gnt), 1 << (((k - 1) / HOLD) % N));
        end

        // Single requester 2: grant, expiry, re-grant without bubble.
        drive(4'b0100, 4'b0100);
        for (int k = 0; k < 9; k++) begin
            adv();
            lit("single", 2, 4'b0100, 1, 1);
        end

        // Requester 2 drops; 1 granted.
        drive(4'b0010, 4'b0000);
        adv();
        lit("grant1", 1, 4'b0010, 1, 0);
        drive(4'b1010, 4'b1000);
        adv();
        lit("hold1", 1, 4'b0010, 1, 0);
        // Early release of 1, requester 2 idle, handoff to 3.
        drive(4'b1000, 4'b1000);
        adv();
        lit("handoff3", 3, 4'b1000, 1, 1);
        // Wrap 3 -> 0.
        drive(4'b0001, 4'b0000);
        adv();
        lit("wrap0", 0, 4'b0001, 1, 0);
        // Nobody requests: idle, sel holds.
        drive(4'b0000, 4'b1111);
        adv();
        lit("idle", 0, 0, 0, 0);

        // Reset in the middle of requester 2's grant.
        drive(4'b0100, 4'b1111);
        adv();
        adv();
        lit("pre_rst", 2, 4'b0100, 1, 1);
        #1 rst_n = 1'b0;
        #1;
        lit("async_rst", 0, 0, 0, 0);
        req = 4'b0110;
        #1 rst_n = 1'b1;
        adv();
        lit("post_rst", 1, 4'b0010, 1, 1);

        // Randomized traffic with occasional resets.
        for (int it = 0; it < 4000; it++) begin
            #1;
            if ($urandom_range(3) == 0) req = N'($urandom);
            din = N'($urandom);
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                adv();
                #1 rst_n = 1'b1;
            end
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
